// File: rtl/bp_fe_fetch_tracker.sv
// rtl/bp_fe_fetch_tracker.sv - credit-limited in-flight fetch tracker with fault folding and in-order response queue
// Define BP_FE_FETCH_TRACKER_BYPASS_EN to forward stage lat_p straight to resp_* when the queue is empty.
module bp_fe_fetch_tracker #(
   parameter int vaddr_width_p = 39,
   parameter int instr_width_p = 32,
   parameter int lat_p         = 2,
   parameter int queue_els_p   = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [vaddr_width_p-1:0] fetch_vaddr_i,
   input  logic                     fetch_v_i,
   output logic                     fetch_ready_o,
   input  logic                     poison_i,
   input  logic                     flush_i,
   input  logic                     itlb_miss_i,
   input  logic                     page_fault_i,
   input  logic                     access_fault_i,
   input  logic [instr_width_p-1:0] data_i,
   input  logic                     data_v_i,
   output logic [vaddr_width_p-1:0] resp_vaddr_o,
   output logic [instr_width_p-1:0] resp_data_o,
   output logic [2:0]               resp_fault_o,
   output logic                     resp_v_o,
   input  logic                     resp_ready_i
);
   localparam int cnt_w_lp = $clog2(queue_els_p + 1);
   localparam int ptr_w_lp = (queue_els_p > 1) ? $clog2(queue_els_p) : 1;
   localparam logic [cnt_w_lp-1:0] cnt_max_lp  = cnt_w_lp'(queue_els_p);
   localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(queue_els_p - 1);

   logic [lat_p-1:0]         v_q, v_d;
   logic [vaddr_width_p-1:0] va_q [lat_p];
   logic [vaddr_width_p-1:0] va_d [lat_p];
   // {access, page, itlb}; stage 1 reads the live inputs, so its slot is not stored
   logic [2:0]               flt_q [1:lat_p-1];
   logic [2:0]               flt_d [1:lat_p-1];

   logic [vaddr_width_p-1:0] q_va_q   [queue_els_p];
   logic [instr_width_p-1:0] q_data_q [queue_els_p];
   logic [2:0]               q_flt_q  [queue_els_p];
   logic [ptr_w_lp-1:0]      rptr_q, rptr_d, wptr_q, wptr_d;
   logic [cnt_w_lp-1:0]      occ_q, occ_d, cnt_q, cnt_d, killed;

   logic                     accept, last_v, enq, deq, pop;
   logic [2:0]               last_code;
   logic [instr_width_p-1:0] last_data;

   assign fetch_ready_o = reset_n_i & (cnt_q < cnt_max_lp) & ~flush_i;
   assign accept        = fetch_v_i & fetch_ready_o;
   assign last_v        = v_q[lat_p-1] & ~poison_i & ~flush_i;
   assign deq           = resp_v_o & resp_ready_i;

   always_comb begin
      if      (flt_q[lat_p-1][2]) last_code = 3'd4;
      else if (flt_q[lat_p-1][1]) last_code = 3'd3;
      else if (flt_q[lat_p-1][0]) last_code = 3'd2;
      else if (!data_v_i)         last_code = 3'd1;
      else                        last_code = 3'd0;
   end
   assign last_data = (last_code == 3'd0) ? data_i : '0;

`ifdef BP_FE_FETCH_TRACKER_BYPASS_EN
   logic bypass_v;
   assign bypass_v     = last_v & (occ_q == '0);
   assign enq          = last_v & ~(bypass_v & resp_ready_i);
   assign pop          = deq & ~bypass_v;
   assign resp_v_o     = (bypass_v | (occ_q != '0)) & ~flush_i;
   assign resp_vaddr_o = bypass_v ? va_q[lat_p-1] : q_va_q[rptr_q];
   assign resp_data_o  = bypass_v ? last_data     : q_data_q[rptr_q];
   assign resp_fault_o = bypass_v ? last_code     : q_flt_q[rptr_q];
`else
   assign enq          = last_v;
   assign pop          = deq;
   assign resp_v_o     = (occ_q != '0) & ~flush_i;
   assign resp_vaddr_o = q_va_q[rptr_q];
   assign resp_data_o  = q_data_q[rptr_q];
   assign resp_fault_o = q_flt_q[rptr_q];
`endif

   always_comb begin
      v_d     = '0;
      va_d    = va_q;
      flt_d   = flt_q;
      v_d[0]  = accept;
      va_d[0] = accept ? fetch_vaddr_i : va_q[0];
      for (int i = 1; i < lat_p; i++) begin
         v_d[i]  = v_q[i-1] & ~poison_i & ~flush_i;
         va_d[i] = va_q[i-1];
      end
      flt_d[1] = v_q[0] ? {access_fault_i, page_fault_i, itlb_miss_i} : 3'b000;
      for (int i = 2; i < lat_p; i++) flt_d[i] = flt_q[i-1];

      killed = '0;
      if (poison_i)
         for (int i = 0; i < lat_p; i++) killed = killed + cnt_w_lp'(v_q[i]);

      rptr_d = rptr_q;
      wptr_d = wptr_q;
      occ_d  = occ_q;
      if (flush_i) begin
         rptr_d = '0;
         wptr_d = '0;
         occ_d  = '0;
      end else begin
         if (enq) wptr_d = (wptr_q == ptr_last_lp) ? '0 : wptr_q + ptr_w_lp'(1);
         if (pop) rptr_d = (rptr_q == ptr_last_lp) ? '0 : rptr_q + ptr_w_lp'(1);
         occ_d = occ_q + cnt_w_lp'(enq) - cnt_w_lp'(pop);
      end

      // a killed entry or a consumed response both return a credit; a flush returns all of them
      if (flush_i) cnt_d = cnt_w_lp'(accept);
      else         cnt_d = cnt_q + cnt_w_lp'(accept) - cnt_w_lp'(deq) - killed;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_q    <= '0;
         rptr_q <= '0;
         wptr_q <= '0;
         occ_q  <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < lat_p; i++) va_q[i] <= '0;
         for (int i = 1; i < lat_p; i++) flt_q[i] <= '0;
         for (int i = 0; i < queue_els_p; i++) begin
            q_va_q[i]   <= '0;
            q_data_q[i] <= '0;
            q_flt_q[i]  <= '0;
         end
      end else begin
         v_q    <= v_d;
         va_q   <= va_d;
         flt_q  <= flt_d;
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         occ_q  <= occ_d;
         cnt_q  <= cnt_d;
         if (enq) begin
            q_va_q[wptr_q]   <= va_q[lat_p-1];
            q_data_q[wptr_q] <= last_data;
            q_flt_q[wptr_q]  <= last_code;
         end
      end
   end
endmodule
